// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit and its register-file neighbours.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FIXUP = 3'd2,
        ST_WB_LO = 3'd3,
        ST_WB_R0 = 3'd4
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Write-port encodings shared with the register file and instruction decoder.
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_R0   = 2'b01;
    localparam logic [1:0] RW_REG  = 2'b11;

    localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

    localparam logic [4:0] LAST_ITER = 5'd15;

endpackage

// File: rtl/muldiv_unit.sv
// Signed 16-bit multiply/divide: 16-cycle shift datapath on magnitudes, sign fixup,
// then two single-write cycles into the register file (dest word, then R0).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     r0,
    output logic [1:0]            reg_write
);

    localparam int W = DATA_W;
    localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

    function automatic logic [W-1:0] neg_word(input logic [W-1:0] v, input logic neg);
        if (neg) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*W-1:0] neg_wide(input logic [2*W-1:0] v, input logic neg);
        if (neg) begin
            return ~v + ONE_2W;
        end else begin
            return v;
        end
    endfunction

    state_e                state_q;
    logic [4:0]            cnt_q;
    logic                  op_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  sign_a_q;
    logic                  sign_b_q;
    logic                  dz_q;
    logic [W-1:0]          mag_q;
    logic [2*W-1:0]        acc_q;
    logic [W-1:0]          res_hi_q;

    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [W-1:0]          write_data_q;
    logic [W-1:0]          r0_q;
    logic [1:0]            reg_write_q;

    // An unsigned W-bit magnitude holds 32768, so 0x8000 needs no special case here.
    logic [W-1:0]   mag_a_s;
    logic [W-1:0]   mag_b_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     div_top_s;
    logic           div_ge_s;
    logic [2*W-1:0] acc_step_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   fix_lo_s;
    logic [W-1:0]   fix_hi_s;

    // Operand magnitudes captured at start.
    always_comb begin
        mag_a_s = neg_word(operand_a, operand_a[W-1]);
        mag_b_s = neg_word(operand_b, operand_b[W-1]);
    end

    // One shift-add (MUL) or restoring-subtract (DIV) iteration on the shared accumulator.
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]} + {1'b0, mag_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]};
        end
        div_top_s = acc_q[2*W-1:W-1];
        div_ge_s  = (div_top_s >= {1'b0, mag_q});
        if (op_q == OP_MUL) begin
            acc_step_s = {mul_sum_s, acc_q[W-1:1]};
        end else if (div_ge_s) begin
            acc_step_s = {div_top_s[W-1:0] - mag_q, acc_q[W-2:0], 1'b1};
        end else begin
            acc_step_s = {div_top_s[W-1:0], acc_q[W-2:0], 1'b0};
        end
    end

    // Sign fixup: remainder follows the dividend's sign (truncating division).
    always_comb begin
        prod_s = neg_wide(acc_q, sign_a_q ^ sign_b_q);
        if (op_q == OP_MUL) begin
            fix_lo_s = prod_s[W-1:0];
            fix_hi_s = prod_s[2*W-1:W];
        end else begin
            fix_lo_s = neg_word(acc_q[W-1:0], sign_a_q ^ sign_b_q);
            fix_hi_s = neg_word(acc_q[2*W-1:W], sign_a_q);
        end
    end

    // Control FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 5'd0;
            op_q         <= OP_MUL;
            dest_q       <= {REG_ADDR_W{1'b0}};
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            dz_q         <= 1'b0;
            mag_q        <= {W{1'b0}};
            acc_q        <= {(2*W){1'b0}};
            res_hi_q     <= {W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
            write_reg_q  <= {REG_ADDR_W{1'b0}};
            write_data_q <= {W{1'b0}};
            r0_q         <= {W{1'b0}};
            reg_write_q  <= RW_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        dest_q   <= dest_reg;
                        sign_a_q <= operand_a[W-1];
                        sign_b_q <= operand_b[W-1];
                        cnt_q    <= 5'd0;
                        busy_q   <= 1'b1;
                        if ((op == OP_DIV) && (operand_b == {W{1'b0}})) begin
                            dz_q         <= 1'b1;
                            res_hi_q     <= operand_a;
                            write_reg_q  <= dest_reg;
                            write_data_q <= DIV0_QUOT;
                            reg_write_q  <= RW_REG;
                            state_q      <= ST_WB_LO;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= ST_RUN;
                            if (op == OP_MUL) begin
                                acc_q <= {{W{1'b0}}, mag_b_s};
                                mag_q <= mag_a_s;
                            end else begin
                                acc_q <= {{W{1'b0}}, mag_a_s};
                                mag_q <= mag_b_s;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_step_s;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    res_hi_q     <= fix_hi_s;
                    write_reg_q  <= dest_q;
                    write_data_q <= fix_lo_s;
                    reg_write_q  <= RW_REG;
                    state_q      <= ST_WB_LO;
                end
                ST_WB_LO: begin
                    r0_q        <= res_hi_q;
                    reg_write_q <= RW_R0;
                    done_q      <= 1'b1;
                    dbz_q       <= dz_q;
                    state_q     <= ST_WB_R0;
                end
                ST_WB_R0: begin
                    reg_write_q <= RW_NONE;
                    done_q      <= 1'b0;
                    dbz_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    reg_write_q <= RW_NONE;
                    done_q      <= 1'b0;
                    dbz_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign write_reg   = write_reg_q;
    assign write_data  = write_data_q;
    assign r0          = r0_q;
    assign reg_write   = reg_write_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: MUL/DIV results, write-back timing,
// divide by zero, ignored start, back-to-back starts and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  dest_reg;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
    logic [15:0] r0;
    logic [1:0]  reg_write;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_reg    (dest_reg),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .r0          (r0),
        .reg_write   (reg_write)
    );

    // Present a request in the current cycle; returns 1ns into cycle 1 with inputs scrambled.
    task automatic launch(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; operand_a = 16'h5A5A; operand_b = 16'h0000; dest_reg = ~d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = 1'b0;
        operand_a = 16'h0000; operand_b = 16'h0000; dest_reg = 4'h0;
        step(2);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || write_reg !== 4'h0 ||
            write_data !== 16'h0000 || r0 !== 16'h0000 || reg_write !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b wreg=%h wdata=%h r0=%h rw=%b, expected all zero",
                     busy, done, div_by_zero, write_reg, write_data, r0, reg_write);
        end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_mul;
        logic [15:0] a_t[3], b_t[3], lo_t[3], hi_t[3];
        logic [3:0]  d_t[3];
        a_t  = '{16'h0051, 16'hFFFE, 16'h8000};
        b_t  = '{16'h0002, 16'h0003, 16'h8000};
        d_t  = '{4'h5, 4'h3, 4'h7};
        lo_t = '{16'h00A2, 16'hFFFA, 16'h0000};
        hi_t = '{16'h0000, 16'hFFFF, 16'h4000};
        for (int i = 0; i < 3; i++) begin
            launch(1'b0, a_t[i], b_t[i], d_t[i]);
            n_checks++;
            if (busy !== 1'b1 || reg_write !== 2'b00) begin
                n_fail++;
                $display("FAIL mul_busy[%0d]: busy=%b rw=%b, expected busy=1 rw=00", i, busy, reg_write);
            end
            step(16);
            n_checks++;
            if (reg_write !== 2'b00 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_cycle17[%0d]: rw=%b done=%b, expected rw=00 done=0", i, reg_write, done);
            end
            step(1);
            n_checks++;
            if (reg_write !== 2'b11 || write_reg !== d_t[i] || write_data !== lo_t[i] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_wb_lo[%0d]: rw=%b wreg=%h wdata=%h done=%b, expected rw=11 wreg=%h wdata=%h done=0",
                         i, reg_write, write_reg, write_data, done, d_t[i], lo_t[i]);
            end
            step(1);
            n_checks++;
            if (reg_write !== 2'b01 || r0 !== hi_t[i] || done !== 1'b1 || div_by_zero !== 1'b0 ||
                write_data !== lo_t[i] || write_reg !== d_t[i]) begin
                n_fail++;
                $display("FAIL mul_wb_r0[%0d]: rw=%b r0=%h done=%b dbz=%b wdata=%h wreg=%h, expected rw=01 r0=%h done=1 dbz=0 wdata=%h wreg=%h",
                         i, reg_write, r0, done, div_by_zero, write_data, write_reg, hi_t[i], lo_t[i], d_t[i]);
            end
            step(1);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 2'b00) begin
                n_fail++;
                $display("FAIL mul_idle[%0d]: busy=%b done=%b rw=%b, expected 0 0 00", i, busy, done, reg_write);
            end
        end
    endtask

    task automatic test_div;
        logic [15:0] a_t[3], b_t[3], q_t[3], r_t[3];
        logic [3:0]  d_t[3];
        a_t = '{16'h0011, 16'hFFF9, 16'h8000};
        b_t = '{16'h0002, 16'h0002, 16'hFFFF};
        d_t = '{4'hE, 4'h2, 4'h1};
        q_t = '{16'h0008, 16'hFFFD, 16'h8000};
        r_t = '{16'h0001, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            launch(1'b1, a_t[i], b_t[i], d_t[i]);
            n_checks++;
            if (busy !== 1'b1 || reg_write !== 2'b00) begin
                n_fail++;
                $display("FAIL div_busy[%0d]: busy=%b rw=%b, expected busy=1 rw=00", i, busy, reg_write);
            end
            step(17);
            n_checks++;
            if (reg_write !== 2'b11 || write_reg !== d_t[i] || write_data !== q_t[i] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL div_wb_lo[%0d]: rw=%b wreg=%h wdata=%h done=%b, expected rw=11 wreg=%h wdata=%h done=0",
                         i, reg_write, write_reg, write_data, done, d_t[i], q_t[i]);
            end
            step(1);
            n_checks++;
            if (reg_write !== 2'b01 || r0 !== r_t[i] || done !== 1'b1 || div_by_zero !== 1'b0 || write_data !== q_t[i]) begin
                n_fail++;
                $display("FAIL div_wb_r0[%0d]: rw=%b r0=%h done=%b dbz=%b wdata=%h, expected rw=01 r0=%h done=1 dbz=0 wdata=%h",
                         i, reg_write, r0, done, div_by_zero, write_data, r_t[i], q_t[i]);
            end
            step(1);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 2'b00) begin
                n_fail++;
                $display("FAIL div_idle[%0d]: busy=%b done=%b rw=%b, expected 0 0 00", i, busy, done, reg_write);
            end
        end
    endtask

    task automatic test_div_by_zero;
        logic [15:0] a_t[2];
        logic [3:0]  d_t[2];
        a_t = '{16'h1234, 16'h8000};
        d_t = '{4'h9, 4'h0};
        for (int i = 0; i < 2; i++) begin
            launch(1'b1, a_t[i], 16'h0000, d_t[i]);
            n_checks++;
            if (busy !== 1'b1 || reg_write !== 2'b11 || write_reg !== d_t[i] || write_data !== 16'hFFFF || done !== 1'b0) begin
                n_fail++;
                $display("FAIL dz_wb_lo[%0d]: busy=%b rw=%b wreg=%h wdata=%h done=%b, expected 1 11 %h ffff 0",
                         i, busy, reg_write, write_reg, write_data, done, d_t[i]);
            end
            step(1);
            n_checks++;
            if (reg_write !== 2'b01 || r0 !== a_t[i] || done !== 1'b1 || div_by_zero !== 1'b1) begin
                n_fail++;
                $display("FAIL dz_wb_r0[%0d]: rw=%b r0=%h done=%b dbz=%b, expected rw=01 r0=%h done=1 dbz=1",
                         i, reg_write, r0, done, div_by_zero, a_t[i]);
            end
            step(1);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || reg_write !== 2'b00) begin
                n_fail++;
                $display("FAIL dz_idle[%0d]: busy=%b done=%b dbz=%b rw=%b, expected 0 0 0 00",
                         i, busy, done, div_by_zero, reg_write);
            end
        end
    endtask

    task automatic test_ignore_start;
        launch(1'b0, 16'h0051, 16'h0002, 4'h5);
        step(4);
        op = 1'b1; operand_a = 16'h0007; operand_b = 16'h0000; dest_reg = 4'h1; start = 1'b1;
        step(1);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || reg_write !== 2'b00) begin
            n_fail++;
            $display("FAIL ignore_start_c6: busy=%b rw=%b, expected busy=1 rw=00", busy, reg_write);
        end
        step(12);
        n_checks++;
        if (reg_write !== 2'b11 || write_reg !== 4'h5 || write_data !== 16'h00A2) begin
            n_fail++;
            $display("FAIL ignore_start_lo: rw=%b wreg=%h wdata=%h, expected rw=11 wreg=5 wdata=00a2",
                     reg_write, write_reg, write_data);
        end
        step(1);
        n_checks++;
        if (reg_write !== 2'b01 || r0 !== 16'h0000 || done !== 1'b1 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_r0: rw=%b r0=%h done=%b dbz=%b, expected rw=01 r0=0000 done=1 dbz=0",
                     reg_write, r0, done, div_by_zero);
        end
        step(1);
    endtask

    task automatic test_back_to_back;
        launch(1'b0, 16'h0100, 16'h0100, 4'h6);
        step(18);
        n_checks++;
        if (reg_write !== 2'b01 || r0 !== 16'h0001 || write_data !== 16'h0000 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: rw=%b r0=%h wdata=%h done=%b, expected rw=01 r0=0001 wdata=0000 done=1",
                     reg_write, r0, write_data, done);
        end
        step(1);
        launch(1'b1, 16'h0064, 16'h0007, 4'hA);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        step(17);
        n_checks++;
        if (reg_write !== 2'b11 || write_reg !== 4'hA || write_data !== 16'h000E) begin
            n_fail++;
            $display("FAIL b2b_second_lo: rw=%b wreg=%h wdata=%h, expected rw=11 wreg=a wdata=000e",
                     reg_write, write_reg, write_data);
        end
        step(1);
        n_checks++;
        if (reg_write !== 2'b01 || r0 !== 16'h0002 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_r0: rw=%b r0=%h done=%b, expected rw=01 r0=0002 done=1", reg_write, r0, done);
        end
        step(1);
    endtask

    task automatic test_reset_abort;
        logic bad;
        launch(1'b1, 16'h0011, 16'h0002, 4'hE);
        step(9);
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || write_reg !== 4'h0 ||
            write_data !== 16'h0000 || r0 !== 16'h0000 || reg_write !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b done=%b dbz=%b wreg=%h wdata=%h r0=%h rw=%b, expected all zero",
                     busy, done, div_by_zero, write_reg, write_data, r0, reg_write);
        end
        step(2);
        reset = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (reg_write !== 2'b00 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_writeback: saw activity after reset, expected none");
        end
        launch(1'b0, 16'hFFFE, 16'h0003, 4'h3);
        step(17);
        n_checks++;
        if (reg_write !== 2'b11 || write_reg !== 4'h3 || write_data !== 16'hFFFA) begin
            n_fail++;
            $display("FAIL abort_recover_lo: rw=%b wreg=%h wdata=%h, expected rw=11 wreg=3 wdata=fffa",
                     reg_write, write_reg, write_data);
        end
        step(1);
        n_checks++;
        if (reg_write !== 2'b01 || r0 !== 16'hFFFF || done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_recover_r0: rw=%b r0=%h done=%b, expected rw=01 r0=ffff done=1", reg_write, r0, done);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
